eth_10g_tx_frame_mux: RTL

//  Merges P_CHANNEL_NUM 64-bit AXIS frame sources onto the single TX AXIS port of one 10G MAC channel.

---
 rtl/eth_10g_pkg.sv | 20 ++
 rtl/eth_rr_arbiter.sv | 32 +++
 rtl/eth_10g_tx_frame_mux.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/eth_10g_pkg.sv
// Shared AXIS widths, frame-mux FSM encoding and keep popcount for the 10G TX path.
package eth_10g_pkg;

  localparam int AXIS_DW = 64;
  localparam int AXIS_KW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_FLUSH = 2'd2
  } tx_mux_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] keep);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'd0, keep[i]};
    return cnt;
  endfunction

endpackage

// File: rtl/eth_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after the pointer, wrapping.
module eth_rr_arbiter
  import eth_10g_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [IW-1:0] idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IW'((int'(ptr) + off) % N);
      if (!grant_vld && req[idx]) begin
        grant_vld     = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_10g_tx_frame_mux.sv
// Frame-atomic round-robin mux of N AXIS sources onto one 10G MAC TX port, with length truncation.
// Optional ETH_TX_MUX_STAT_EN adds per-channel frame and truncation counters.
module eth_10g_tx_frame_mux
  import eth_10g_pkg::*;
#(
  parameter int          P_CHANNEL_NUM = 4,
  parameter logic [7:0]  P_MIN_LENGTH  = 8'd64,
  parameter logic [14:0] P_MAX_LENGTH  = 15'd9600
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_link_up,
  input  logic [P_CHANNEL_NUM-1:0]         s_axis_tvalid,
  output logic [P_CHANNEL_NUM-1:0]         s_axis_tready,
  input  logic [P_CHANNEL_NUM*AXIS_DW-1:0] s_axis_tdata,
  input  logic [P_CHANNEL_NUM*AXIS_KW-1:0] s_axis_tkeep,
  input  logic [P_CHANNEL_NUM-1:0]         s_axis_tlast,
  input  logic [P_CHANNEL_NUM-1:0]         s_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [AXIS_DW-1:0]               m_axis_tdata,
  output logic [AXIS_KW-1:0]               m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tuser,
  output logic [P_CHANNEL_NUM-1:0]         o_trunc,
  output logic [P_CHANNEL_NUM-1:0]         o_runt
`ifdef ETH_TX_MUX_STAT_EN
  ,
  output logic [P_CHANNEL_NUM*32-1:0]      o_frame_cnt,
  output logic [P_CHANNEL_NUM*16-1:0]      o_trunc_cnt
`endif
);

  localparam int N  = P_CHANNEL_NUM;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  tx_mux_state_t state, state_nxt;
  logic [IW-1:0] grant, rr_ptr, arb_idx;
  logic [N-1:0]  grant_oh, arb_oh;
  logic          arb_vld;
  logic [14:0]   byte_cnt, cnt_sat;
  logic [15:0]   cnt_sum;
  logic          sel_valid, sel_last, sel_user;
  logic [AXIS_DW-1:0] sel_data;
  logic [AXIS_KW-1:0] sel_keep;
  logic          beat_acc, trunc_beat, frame_end, grant_take;

  eth_rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req       (s_axis_tvalid),
    .ptr       (rr_ptr),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  always_comb begin
    sel_valid = s_axis_tvalid[grant];
    sel_last  = s_axis_tlast[grant];
    sel_user  = s_axis_tuser[grant];
    sel_data  = s_axis_tdata[grant*AXIS_DW +: AXIS_DW];
    sel_keep  = s_axis_tkeep[grant*AXIS_KW +: AXIS_KW];
    cnt_sum   = {1'b0, byte_cnt} + {12'd0, popcount8(sel_keep)};
    cnt_sat   = cnt_sum[15] ? 15'h7FFF : cnt_sum[14:0];
  end

  assign grant_take = (state == ST_IDLE) && i_link_up && arb_vld;

  always_comb begin
    state_nxt     = state;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = '0;
    o_trunc       = '0;
    o_runt        = '0;
    beat_acc      = 1'b0;
    trunc_beat    = 1'b0;
    frame_end     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (grant_take) state_nxt = ST_PASS;
      end
      ST_PASS: begin
        // A tlast beat that hits the limit exactly is a normal end, so tlast wins.
        trunc_beat    = sel_valid && !sel_last && (cnt_sat >= P_MAX_LENGTH);
        m_axis_tvalid = sel_valid;
        m_axis_tdata  = sel_data;
        m_axis_tkeep  = sel_keep;
        m_axis_tlast  = sel_last | trunc_beat;
        m_axis_tuser  = sel_user | trunc_beat;
        s_axis_tready = m_axis_tready ? grant_oh : '0;
        beat_acc      = sel_valid && m_axis_tready;
        if (beat_acc) begin
          if (sel_last) begin
            state_nxt = ST_IDLE;
            frame_end = 1'b1;
            if (cnt_sat < {7'd0, P_MIN_LENGTH}) o_runt = grant_oh;
          end else if (trunc_beat) begin
            state_nxt = ST_FLUSH;
            o_trunc   = grant_oh;
          end
        end
      end
      ST_FLUSH: begin
        s_axis_tready = grant_oh;
        if (sel_valid && sel_last) begin
          state_nxt = ST_IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= IW'(N - 1);
      grant    <= '0;
      grant_oh <= '0;
      byte_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant_take) begin
        grant    <= arb_idx;
        grant_oh <= arb_oh;
        byte_cnt <= '0;
      end
      if (beat_acc) byte_cnt <= cnt_sat;
      if (frame_end) begin
        rr_ptr   <= grant;
        byte_cnt <= '0;
      end
    end
  end

`ifdef ETH_TX_MUX_STAT_EN
  logic out_last_acc;
  assign out_last_acc = beat_acc && m_axis_tlast;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_frame_cnt <= '0;
      o_trunc_cnt <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (out_last_acc && grant_oh[k])
          o_frame_cnt[k*32 +: 32] <= o_frame_cnt[k*32 +: 32] + 32'd1;
        if (o_trunc[k])
          o_trunc_cnt[k*16 +: 16] <= o_trunc_cnt[k*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
